// File: rtl/scroll_controller_if.sv
// Control, message-write and display-drive signals of the scrolling LED message controller.
interface scroll_controller_if;
  logic       run;
  logic       dir;
  logic       step;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       an3, an2, an1, an0;
  logic [3:0] digit;
  logic [3:0] ptr;
  logic       frame_start;

  modport master (
    output run, dir, step, wr_en, wr_addr, wr_data,
    input  an3, an2, an1, an0, digit, ptr, frame_start
  );

  modport slave (
    input  run, dir, step, wr_en, wr_addr, wr_data,
    output an3, an2, an1, an0, digit, ptr, frame_start
  );
endinterface

// File: rtl/scroll_controller.sv
// Four-digit multiplexed display scanning a 16-entry message buffer, with automatic
// or manually stepped scrolling applied only at frame boundaries.
module scroll_controller #(
  parameter int REFRESH_DIV = 16,
  parameter int SCROLL_DIV  = 4096
) (
  input logic                 clk,
  input logic                 reset,
  scroll_controller_if.slave  bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SCROLL_DIV);

  if (REFRESH_DIV < 2 || REFRESH_DIV > 65535) begin : g_bad_refresh
    $error("scroll_controller: REFRESH_DIV out of range 2..65535");
  end
  if (SCROLL_DIV < 4*REFRESH_DIV) begin : g_bad_scroll
    $error("scroll_controller: SCROLL_DIV must be >= 4*REFRESH_DIV");
  end

  typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2, SLOT3 = 2'd3} slot_t;

  slot_t         slot_q, slot_d;
  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] scr_cnt;
  logic [3:0]    msg_mem [16];
  logic          step_q, pending, pend_dir;
  logic [3:0]    ptr_q, ptr_d, rd_idx, digit_q, an_q, an_d;
  logic          fs_q;
  logic          ref_tc, frame_edge, tick, step_req, req, move, move_dir;

  assign ref_tc     = (ref_cnt == RW'(REFRESH_DIV-1));
  assign frame_edge = ref_tc && (slot_q == SLOT0);
  assign tick       = bus.run && (scr_cnt == SW'(SCROLL_DIV-1));
  assign step_req   = !bus.run && bus.step && !step_q;
  assign req        = tick || step_req;

  // A request landing on the frame edge itself is applied immediately with the live dir.
  assign move     = frame_edge && (pending || req);
  assign move_dir = pending ? pend_dir : bus.dir;
  assign ptr_d    = move ? (move_dir ? ptr_q - 4'd1 : ptr_q + 4'd1) : ptr_q;

  // Slot s shows entry ptr+3-s, so an3 carries the leftmost character.
  assign rd_idx = ptr_d + 4'd3 - {2'b00, slot_d};
  assign an_d   = ~(4'b0001 << slot_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= SLOT3;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    if (ref_tc) begin
      case (slot_q)
        SLOT3:   slot_d = SLOT2;
        SLOT2:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT0;
        default: slot_d = SLOT3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) msg_mem[i] <= 4'(i);
    end else if (bus.wr_en) begin
      msg_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt  <= '0;
      scr_cnt  <= '0;
      step_q   <= 1'b0;
      pending  <= 1'b0;
      pend_dir <= 1'b0;
      ptr_q    <= 4'd0;
      an_q     <= 4'b0111;
      digit_q  <= 4'd0;
      fs_q     <= 1'b0;
    end else begin
      ref_cnt <= ref_tc ? '0 : ref_cnt + RW'(1);
      scr_cnt <= (!bus.run || tick) ? '0 : scr_cnt + SW'(1);
      step_q  <= bus.step;
      ptr_q   <= ptr_d;
      fs_q    <= frame_edge;
      // Digit is latched only on slot changes so anode and character switch together.
      if (ref_tc) begin
        an_q    <= an_d;
        digit_q <= msg_mem[rd_idx];
      end
      if (frame_edge) begin
        pending <= 1'b0;
      end else if (req && !pending) begin
        pending  <= 1'b1;
        pend_dir <= bus.dir;
      end
    end
  end

  assign bus.an3         = an_q[3];
  assign bus.an2         = an_q[2];
  assign bus.an1         = an_q[1];
  assign bus.an0         = an_q[0];
  assign bus.digit       = digit_q;
  assign bus.ptr         = ptr_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller at REFRESH_DIV=2, SCROLL_DIV=16; t counts posedges since reset release.
module tb_scroll_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scroll_controller_if bus();

  scroll_controller #(.REFRESH_DIV(2), .SCROLL_DIV(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    t++;
  endtask

  task automatic upto(input int n);
    while (t < n) cyc();
  endtask

  function automatic logic [3:0] anv();
    return {bus.an3, bus.an2, bus.an1, bus.an0};
  endfunction

  initial begin
    int slot_of [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    logic [3:0] e_an;
    logic [3:0] prev, e_ptr;
    int moves;

    bus.run = 0; bus.dir = 0; bus.step = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_an", anv(), 4'b0111);
    chk("rst_digit", bus.digit, 0);
    chk("rst_ptr", bus.ptr, 0);
    chk("rst_fs", bus.frame_start, 0);
    reset = 0; t = 0;

    // idle scan: slots 3,2,1,0 every 2 clk, digits 0..3, frame_start each 8 clk
    for (int k = 1; k <= 16; k++) begin
      cyc();
      e_an = 4'b1111;
      e_an[slot_of[k%8]] = 1'b0;
      chk("scan_an", anv(), e_an);
      chk("scan_digit", bus.digit, 3 - slot_of[k%8]);
      chk("scan_fs", bus.frame_start, (k % 8 == 0) ? 1 : 0);
    end
    chk("scan_ptr", bus.ptr, 0);

    // write entry 1 while it is displayed: old value held until next frame
    upto(18);
    chk("wr_pre_an", anv(), 4'b1011);
    chk("wr_pre_digit", bus.digit, 1);
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 9;
    cyc();
    bus.wr_en = 0;
    chk("wr_same_digit", bus.digit, 1);
    chk("wr_same_an", anv(), 4'b1011);
    upto(24);
    chk("wr_fs", bus.frame_start, 1);
    chk("wr_frame_digit", bus.digit, 0);
    upto(26);
    chk("wr_new_digit", bus.digit, 9);
    chk("wr_new_an", anv(), 4'b1011);
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 1;
    cyc();
    bus.wr_en = 0;

    // manual step right from ptr 0, step held high
    bus.dir = 1; bus.step = 1;
    upto(31);
    chk("stepR_hold_ptr", bus.ptr, 0);
    cyc();
    chk("stepR_ptr", bus.ptr, 15);
    chk("stepR_fs", bus.frame_start, 1);
    chk("stepR_d3", bus.digit, 15);
    upto(34); chk("stepR_d2", bus.digit, 0);
    upto(36); chk("stepR_d1", bus.digit, 1);
    upto(38); chk("stepR_d0", bus.digit, 2);
    upto(40); chk("stepR_held1", bus.ptr, 15);
    upto(48); chk("stepR_held2", bus.ptr, 15);
    bus.step = 0; bus.dir = 0;

    // two step edges in one frame; second (with dir=1) is dropped
    upto(49); bus.step = 1;
    cyc();    bus.step = 0;
    cyc();    bus.step = 1; bus.dir = 1;
    cyc();    bus.step = 0; bus.dir = 0;
    upto(55);
    chk("dbl_pre_ptr", bus.ptr, 15);
    cyc();
    chk("dbl_ptr", bus.ptr, 0);
    chk("dbl_fs", bus.frame_start, 1);
    chk("dbl_digit", bus.digit, 0);
    upto(63);
    chk("dbl_once_ptr", bus.ptr, 0);

    // step edge coincident with the frame edge is applied on that edge
    bus.step = 1; bus.dir = 1;
    cyc();
    bus.step = 0; bus.dir = 0;
    chk("coin_ptr", bus.ptr, 15);
    chk("coin_fs", bus.frame_start, 1);
    chk("coin_digit", bus.digit, 15);
    upto(72);
    chk("coin_after_ptr", bus.ptr, 15);

    // automatic scroll left for 64 clk; ticks align with frame edges
    bus.run = 1; bus.dir = 0;
    prev = bus.ptr; moves = 0;
    for (int k = 73; k <= 136; k++) begin
      cyc();
      if (bus.ptr !== prev) begin
        moves++;
        e_ptr = prev + 4'd1;
        chk("auto_fs", bus.frame_start, 1);
        chk("auto_ptr", bus.ptr, e_ptr);
        chk("auto_digit", bus.digit, e_ptr);
        prev = bus.ptr;
      end
    end
    bus.run = 0;
    chk("auto_moves", moves, 4);
    chk("auto_final_ptr", bus.ptr, 3);
    upto(152);
    chk("auto_stop_ptr", bus.ptr, 3);

    // reach ptr 5, leave a move pending, then reset mid-frame
    upto(153); bus.step = 1;
    cyc();     bus.step = 0;
    upto(160); chk("pre_rst_ptr4", bus.ptr, 4);
    upto(161); bus.step = 1;
    cyc();     bus.step = 0;
    upto(164); bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 7;
    cyc();     bus.wr_en = 0;
    upto(168); chk("pre_rst_ptr5", bus.ptr, 5);
    upto(169); bus.step = 1;
    cyc();     bus.step = 0;
    chk("pend_ptr5", bus.ptr, 5);
    cyc();
    reset = 1;
    #1;
    chk("arst_ptr", bus.ptr, 0);
    chk("arst_an", anv(), 4'b0111);
    chk("arst_digit", bus.digit, 0);
    chk("arst_fs", bus.frame_start, 0);
    repeat (3) @(negedge clk);
    reset = 0; t = 0;
    cyc();
    chk("rel_t1_an", anv(), 4'b0111);
    cyc();
    chk("rel_t2_an", anv(), 4'b1011);
    chk("rel_t2_digit", bus.digit, 1);
    upto(4);
    chk("rel_mem_digit", bus.digit, 2);
    upto(8);
    chk("rel_fs", bus.frame_start, 1);
    chk("rel_ptr", bus.ptr, 0);
    upto(16);
    chk("rel_ptr_late", bus.ptr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
